// File: rtl/ascii_hex_word_packer.sv
// ---------------------------------------------------------------------------
// ascii_hex_word_packer
//
// Purpose:
//   Turns a stream of ASCII bytes from the UART receive path into binary
//   words for the debug-unit command decoder. Hex-digit characters are
//   converted to nibbles and shifted into an accumulator. A delimiter (space,
//   CR or LF) closes the token and presents the word on a valid/ready
//   handshake. Bad characters, too many digits and bytes arriving while a
//   word is still waiting to be taken are reported with a one-cycle error
//   pulse and a cause code.
//
// Parameters:
//   WORD_W      output word width, a multiple of 4 and at least 4
//   MAX_DIGITS  digits per word, derived as WORD_W/4 (not overridable)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_data     ASCII byte from the UART receiver
//   rx_valid    one-cycle strobe qualifying rx_data (no backpressure)
//   word_out    assembled word, right-aligned and zero-extended
//   word_valid  word_out is valid, held until accepted
//   word_ready  downstream accepts when word_valid & word_ready at an edge
//   digit_cnt   digits accumulated in the current token
//   err         one-cycle error pulse
//   err_code    error cause: 01 invalid char, 10 digit overflow,
//               11 byte dropped while a word is pending
//
// Build option:
//   ASCII_HEX_UPPERCASE_EN  when defined, 'A'..'F' are accepted as digits
//                           (values 10..15); otherwise they are invalid.
// ---------------------------------------------------------------------------
module ascii_hex_word_packer #(
   parameter  int WORD_W     = 32,
   localparam int MAX_DIGITS = WORD_W / 4,
   localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [CNT_W-1:0]  digit_cnt,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DISCARD,
      OUT
   } state_t;

   localparam logic [1:0]       CODE_INVALID  = 2'b01;
   localparam logic [1:0]       CODE_OVERFLOW = 2'b10;
   localparam logic [1:0]       CODE_DROPPED  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(MAX_DIGITS);

   state_t            state;
   state_t            state_nx;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] acc_nx;
   logic [WORD_W-1:0] word_nx;
   logic              valid_nx;
   logic [CNT_W-1:0]  cnt_nx;
   logic              err_nx;
   logic [1:0]        code_nx;

   logic              is_digit;
   logic              is_delim;
   logic [3:0]        nibble;

   // Character classifier. Decimal digits and letters both keep their value
   // in the low nibble of the ASCII code ('a'/'A' = x1 ... 'f'/'F' = x6), so
   // letters only need +9 to land on 10..15.
   always_comb begin
      is_digit = 1'b0;
      is_delim = 1'b0;
      nibble   = 4'd0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         is_digit = 1'b1;
         nibble   = rx_data[3:0];
      end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
         is_digit = 1'b1;
         nibble   = rx_data[3:0] + 4'd9;
      end
`ifdef ASCII_HEX_UPPERCASE_EN
      else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
         is_digit = 1'b1;
         nibble   = rx_data[3:0] + 4'd9;
      end
`endif
      else if (rx_data == 8'h20 || rx_data == 8'h0D || rx_data == 8'h0A) begin
         is_delim = 1'b1;
      end
   end

   // Next-state and next-output logic. Every output is registered, so this
   // block computes the values each register takes at the coming edge.
   // err defaults to 0 so it only ever pulses for a single cycle, while
   // err_code holds its last cause between pulses.
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      word_nx  = word_out;
      valid_nx = word_valid;
      cnt_nx   = digit_cnt;
      err_nx   = 1'b0;
      code_nx  = err_code;

      case (state)
         IDLE: begin
            // Delimiters here are empty tokens and are ignored.
            if (rx_valid) begin
               if (is_digit) begin
                  acc_nx   = WORD_W'(nibble);
                  cnt_nx   = CNT_W'(1);
                  state_nx = ACCUM;
               end else if (!is_delim) begin
                  err_nx  = 1'b1;
                  code_nx = CODE_INVALID;
               end
            end
         end

         ACCUM: begin
            if (rx_valid) begin
               if (is_digit) begin
                  if (digit_cnt == CNT_FULL) begin
                     err_nx   = 1'b1;
                     code_nx  = CODE_OVERFLOW;
                     state_nx = DISCARD;
                  end else begin
                     // Shift form keeps this legal for WORD_W = 4, where a
                     // part-select of the upper bits would be empty.
                     acc_nx = (acc << 4) | WORD_W'(nibble);
                     cnt_nx = digit_cnt + CNT_W'(1);
                  end
               end else if (is_delim) begin
                  word_nx  = acc;
                  valid_nx = 1'b1;
                  state_nx = OUT;
               end else begin
                  err_nx   = 1'b1;
                  code_nx  = CODE_INVALID;
                  state_nx = DISCARD;
               end
            end
         end

         DISCARD: begin
            // A poisoned token is swallowed up to its delimiter; digit_cnt
            // keeps its final value until then so the failure stays visible.
            if (rx_valid && is_delim) begin
               acc_nx   = '0;
               cnt_nx   = '0;
               state_nx = IDLE;
            end
         end

         OUT: begin
            // There is no way to stall the UART, so any byte arriving while
            // the word waits is lost and reported, even on the accept edge.
            if (rx_valid) begin
               err_nx  = 1'b1;
               code_nx = CODE_DROPPED;
            end
            if (word_valid && word_ready) begin
               valid_nx = 1'b0;
               acc_nx   = '0;
               cnt_nx   = '0;
               state_nx = IDLE;
            end
         end

         default: begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
            valid_nx = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset discards any partial token or pending
   // word outright; nothing is emitted after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         digit_cnt  <= '0;
         err        <= 1'b0;
         err_code   <= 2'b00;
      end else begin
         state      <= state_nx;
         acc        <= acc_nx;
         word_out   <= word_nx;
         word_valid <= valid_nx;
         digit_cnt  <= cnt_nx;
         err        <= err_nx;
         err_code   <= code_nx;
      end
   end

endmodule

// File: tb/tb_ascii_hex_word_packer.sv
// ---------------------------------------------------------------------------
// tb_ascii_hex_word_packer
//
// Drives ASCII bytes into ascii_hex_word_packer (WORD_W = 32) and compares
// every registered output against a token-level reference model: the model
// keeps the current token as a queue of digit values plus "discarding" and
// "pending" flags, and forms the word with ordinary base-16 arithmetic.
// Directed scenarios are followed by a randomized byte stream.
// ---------------------------------------------------------------------------
module tb_ascii_hex_word_packer;

   localparam int WORD_W = 32;
   localparam int MAXD   = WORD_W / 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        word_ready;
   logic [31:0] word_out;
   logic        word_valid;
   logic [3:0]  digit_cnt;
   logic        err;
   logic [1:0]  err_code;

   int passCount  = 0;
   int checkCount = 0;
   int failCount  = 0;

   // Reference model state
   bit          mPending;
   bit          mDiscard;
   int          mDigits[$];
   logic [31:0] mWord;
   bit          mErr;
   logic [1:0]  mCode;

   string       hexChars = "0123456789abcdef";

   ascii_hex_word_packer #(.WORD_W(WORD_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .digit_cnt  (digit_cnt),
      .err        (err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   // Character value: 0..15 for a digit, 16 for a delimiter, -1 otherwise.
   function automatic int classify(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
      if (b >= 8'h61 && b <= 8'h66) return int'(b) - 97 + 10;
`ifdef ASCII_HEX_UPPERCASE_EN
      if (b >= 8'h41 && b <= 8'h46) return int'(b) - 65 + 10;
`endif
      if (b == 8'h20 || b == 8'h0D || b == 8'h0A) return 16;
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mPending = 1'b0;
      mDiscard = 1'b0;
      mDigits.delete();
      mWord    = '0;
      mErr     = 1'b0;
      mCode    = 2'b00;
   endtask

   // One clock edge of the token-level model.
   task automatic modelStep(input bit valid, input logic [7:0] b, input bit ready);
      int v;
      mErr = 1'b0;
      if (mPending) begin
         if (valid) begin
            mErr  = 1'b1;
            mCode = 2'b11;
         end
         if (ready) begin
            mPending = 1'b0;
            mDigits.delete();
         end
      end else if (valid) begin
         v = classify(b);
         if (mDiscard) begin
            if (v == 16) begin
               mDiscard = 1'b0;
               mDigits.delete();
            end
         end else if (v >= 0 && v < 16) begin
            if (mDigits.size() == MAXD) begin
               mErr     = 1'b1;
               mCode    = 2'b10;
               mDiscard = 1'b1;
            end else begin
               mDigits.push_back(v);
            end
         end else if (v == 16) begin
            if (mDigits.size() > 0) begin
               mPending = 1'b1;
               mWord    = '0;
               foreach (mDigits[i]) mWord = 32'(mWord * 16 + 32'(mDigits[i]));
            end
         end else begin
            mErr  = 1'b1;
            mCode = 2'b01;
            if (mDigits.size() > 0) mDiscard = 1'b1;
         end
      end
   endtask

   task automatic compareModel();
      checkOutput("word_valid", 64'(word_valid), 64'(mPending));
      if (mPending) checkOutput("word_out", 64'(word_out), 64'(mWord));
      checkOutput("digit_cnt", 64'(digit_cnt), 64'(mDigits.size()));
      checkOutput("err", 64'(err), 64'(mErr));
      checkOutput("err_code", 64'(err_code), 64'(mCode));
   endtask

   // Present one cycle of inputs, let the edge happen, then check.
   task automatic applyStimulus(input bit valid, input logic [7:0] b, input bit ready);
      @(negedge clk);
      rx_valid   = valid;
      rx_data    = b;
      word_ready = ready;
      @(posedge clk);
      #1;
      modelStep(valid, b, ready);
      compareModel();
      rx_valid = 1'b0;
   endtask

   task automatic sendString(input string s, input bit ready);
      for (int i = 0; i < s.len(); i++) applyStimulus(1'b1, s[i], ready);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n      = 1'b0;
      rx_valid   = 1'b0;
      word_ready = 1'b0;
      #2;
      checkOutput("rst_word_valid", 64'(word_valid), 64'(0));
      checkOutput("rst_word_out", 64'(word_out), 64'(0));
      checkOutput("rst_digit_cnt", 64'(digit_cnt), 64'(0));
      checkOutput("rst_err", 64'(err), 64'(0));
      checkOutput("rst_err_code", 64'(err_code), 64'(0));
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      int         r;
      rst_n      = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      word_ready = 1'b0;
      modelReset();
      doReset();

      // Basic word, then acceptance.
      $display("[TB] basic word");
      sendString("12af ", 1'b0);
      checkOutput("basic_valid", 64'(word_valid), 64'(1));
      checkOutput("basic_word", 64'(word_out), 64'h12AF);
      checkOutput("basic_cnt", 64'(digit_cnt), 64'(4));
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("basic_accept_valid", 64'(word_valid), 64'(0));
      checkOutput("basic_accept_cnt", 64'(digit_cnt), 64'(0));

      // Full-width word held under backpressure, with a dropped byte.
      $display("[TB] backpressure");
      sendString("deadbeef", 1'b0);
      applyStimulus(1'b1, 8'h0D, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0);
         checkOutput("hold_word", 64'(word_out), 64'hDEADBEEF);
      end
      applyStimulus(1'b1, 8'h37, 1'b0);
      checkOutput("drop_err", 64'(err), 64'(1));
      checkOutput("drop_code", 64'(err_code), 64'(3));
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("hold_accept_valid", 64'(word_valid), 64'(0));
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("single_accept", 64'(word_valid), 64'(0));

      // Digit overflow: nine digits into a 32-bit word.
      $display("[TB] overflow");
      sendString("12345678", 1'b0);
      applyStimulus(1'b1, 8'h39, 1'b0);
      checkOutput("ovf_err", 64'(err), 64'(1));
      checkOutput("ovf_code", 64'(err_code), 64'(2));
      applyStimulus(1'b1, 8'h20, 1'b0);
      checkOutput("ovf_no_word", 64'(word_valid), 64'(0));
      sendString("5 ", 1'b0);
      checkOutput("after_ovf_word", 64'(word_out), 64'h5);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Invalid character mid-token, then lone delimiters.
      $display("[TB] invalid character");
      sendString("12g", 1'b0);
      checkOutput("inv_err", 64'(err), 64'(1));
      checkOutput("inv_code", 64'(err_code), 64'(1));
      sendString("3 ", 1'b0);
      checkOutput("inv_no_word", 64'(word_valid), 64'(0));
      applyStimulus(1'b1, 8'h20, 1'b0);
      applyStimulus(1'b1, 8'h0D, 1'b0);
      applyStimulus(1'b1, 8'h0A, 1'b0);
      checkOutput("delim_no_err", 64'(err), 64'(0));
      checkOutput("delim_no_word", 64'(word_valid), 64'(0));

      // Reset mid-token and while a word is pending.
      $display("[TB] reset cases");
      sendString("ab", 1'b0);
      doReset();
      sendString("c ", 1'b0);
      checkOutput("post_rst_word", 64'(word_out), 64'hC);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", 64'(word_valid), 64'(0));
      checkOutput("async_rst_cnt", 64'(digit_cnt), 64'(0));
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;

      // Uppercase letters.
      $display("[TB] uppercase");
      applyStimulus(1'b1, 8'h41, 1'b0);
`ifdef ASCII_HEX_UPPERCASE_EN
      applyStimulus(1'b1, 8'h42, 1'b0);
      applyStimulus(1'b1, 8'h20, 1'b0);
      checkOutput("upper_word", 64'(word_out), 64'hAB);
      applyStimulus(1'b0, 8'h00, 1'b1);
`else
      checkOutput("upper_err", 64'(err), 64'(1));
      checkOutput("upper_code", 64'(err_code), 64'(1));
      applyStimulus(1'b1, 8'h42, 1'b0);
      applyStimulus(1'b1, 8'h20, 1'b0);
      checkOutput("upper_no_word", 64'(word_valid), 64'(0));
`endif

      // Randomized byte stream against the model.
      $display("[TB] random stream");
      doReset();
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 55) begin
            b = hexChars[int'($urandom_range(0, 15))];
         end else if (r < 70) begin
            case ($urandom_range(0, 2))
               0:       b = 8'h20;
               1:       b = 8'h0D;
               default: b = 8'h0A;
            endcase
         end else if (r < 78) begin
            b = 8'h41 + 8'($urandom_range(0, 5));
         end else begin
            b = 8'($urandom_range(0, 255));
         end
         applyStimulus($urandom_range(0, 9) < 8, b, $urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/ascii_hex_word_packer.md
Name: ascii_hex_word_packer

Overview:
- Consumes a stream of ASCII bytes from the UART receive path, one byte per `rx_valid` strobe.
- Converts each hex-digit character to a nibble and shifts it into a word register.
- On a delimiter character, presents the assembled word to the downstream command/debug logic using a valid/ready handshake.
- Sits between the UART byte receiver and the debug-unit command decoder.

Parameters:
- WORD_W, 32, output word width in bits; must be a multiple of 4 and at least 4.
- MAX_DIGITS, WORD_W/4, maximum digits per word; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  ASCII byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; `rx_data` is valid this cycle. There is no backpressure to the receiver.
- word_out  output  WORD_W  assembled word, right-aligned and zero-extended.
- word_valid  output  1  `word_out` is valid; held until accepted.
- word_ready  input  1  downstream accepts when `word_valid` and `word_ready` are both high at a clock edge.
- digit_cnt  output  $clog2(MAX_DIGITS+1)  digits accumulated in the current token.
- err  output  1  one-cycle error pulse.
- err_code  output  2  cause of the error; valid when `err` is high. 01 = invalid character, 10 = digit overflow, 11 = byte dropped while output pending.

Behaviour:
- Character classes:
  - Digit: 0x30–0x39 map to 0–9; 0x61–0x66 map to a–f.
  - Delimiter: 0x20, 0x0D, 0x0A.
  - Every other byte is invalid.
- Reset (async, `rst_n` = 0):
  - State goes to IDLE.
  - acc, `word_out`, `digit_cnt`, `word_valid`, `err` and `err_code` all go to 0.
  - Reset asserted mid-token or with an output pending discards everything. No word is emitted after reset releases.
- All outputs are registered. `err` is high for exactly one cycle after the offending byte's edge; otherwise `err` = 0 and `err_code` holds its last value.
- Bytes are evaluated only on cycles where `rx_valid` = 1.
- State machine:
  - IDLE:
    - digit: acc = nibble, `digit_cnt` = 1, go to ACCUM.
    - delimiter: ignored; empty tokens produce no output.
    - invalid: `err`, code 01, stay in IDLE.
  - ACCUM:
    - digit with `digit_cnt` < MAX_DIGITS: acc = {acc[WORD_W-5:0], nibble}, `digit_cnt` + 1.
    - digit with `digit_cnt` = MAX_DIGITS: `err`, code 10, go to DISCARD.
    - delimiter: `word_out` = acc, `word_valid` = 1 at the next edge, go to OUT.
    - invalid: `err`, code 01, go to DISCARD.
  - DISCARD:
    - delimiter: acc = 0, `digit_cnt` = 0, go to IDLE; no word is emitted.
    - digits and invalid bytes: silently ignored, no further `err`.
  - OUT:
    - `word_valid` = 1 and `word_out` stable.
    - On handshake (`word_valid` & `word_ready`): `word_valid` = 0, acc = 0, `digit_cnt` = 0, go to IDLE at that edge.
    - Any byte with `rx_valid` = 1 while in OUT is dropped: `err`, code 11. This includes the handshake cycle itself; the handshake still completes.
- Latency: delimiter presented at edge N gives `word_valid` = 1 and a stable `word_out` from edge N onward.
- Leading zeros count toward MAX_DIGITS. For example, "000000001" with WORD_W = 32 is an overflow.
- `digit_cnt` reads 0 in IDLE, holds its final value in DISCARD and OUT, and clears on the return to IDLE.

Optional Feature:
- Macro: ASCII_HEX_UPPERCASE_EN.
- Defined: 0x41–0x46 are also digits, mapping to A–F (values 10–15), identical to lowercase.
- Undefined: 0x41–0x46 are invalid characters (code 01).

Test Plan:
- Reset, then bytes "1","2","a","f"," " → `word_valid` one cycle after the space's edge; `word_out` = 0x000012AF, `digit_cnt` = 4. `word_ready` = 1 → `word_valid` falls next edge, `digit_cnt` = 0.
- "deadbeef",0x0D with `word_ready` held 0 for 5 cycles → `word_out` = 0xDEADBEEF stable all 5 cycles. A "7" sent during the wait gives `err` = 1 with code 11. Raise `word_ready` → single acceptance, return to IDLE.
- "123456789"," " (9 digits, WORD_W = 32) → `err` code 10 on the 9th digit; no `word_valid`. A following "5"," " → `word_out` = 0x00000005.
- "12","g","3"," " → `err` code 01 on "g", then DISCARD; no word. Spaces/CR/LF alone in IDLE → no output, no `err`.
- Assert `rst_n` = 0 mid-token after "ab", release, send "c"," " → `word_out` = 0x0000000C. Assert reset while in OUT → `word_valid` drops immediately (async).
- "AB"," " → with ASCII_HEX_UPPERCASE_EN: `word_out` = 0x000000AB. Without it: `err` code 01 on "A", no word.
